// File: rtl/pipe_dmem_ctrl.sv
// Memory-stage data RAM with request/response handshake,
// programmable access latency and word-address bounds check.
module pipe_dmem_ctrl #(
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 64,
   parameter int DEPTH   = 512,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic              err_seen
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);
   localparam logic [3:0] CNT_INIT =
      (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
   localparam logic BYPASS = (LATENCY == 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic accept;
   logic go_resp;

   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              err_q;

   logic              c_write;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              c_err;
   logic [AW-1:0]     c_idx;
   logic              req_err;

   logic [DATA_W-1:0] mem [DEPTH];

   assign req_ready = (state != WAIT);
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid && req_ready;
   assign req_err   = (req_addr >= LIMIT);

   // With single-cycle latency the commit edge is the accept
   // edge, so the live request is used instead of the latches.
   assign c_write = BYPASS ? req_write : wr_q;
   assign c_addr  = BYPASS ? req_addr  : addr_q;
   assign c_wdata = BYPASS ? req_wdata : wdata_q;
   assign c_err   = BYPASS ? req_err   : err_q;
   assign c_idx   = c_addr[AW-1:0];

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      go_resp  = 1'b0;
      unique case (state)
         IDLE, RESP: begin
            if (accept) begin
               if (BYPASS) begin
                  state_nx = RESP;
                  go_resp  = 1'b1;
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = CNT_INIT;
               end
            end else begin
               state_nx = IDLE;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_nx = RESP;
               go_resp  = 1'b1;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         wr_q    <= req_write;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         err_q   <= req_err;
      end
   end

   // Array is intentionally not reset.
   always_ff @(posedge clk) begin
      if (go_resp && c_write && !c_err)
         mem[c_idx] <= c_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
         err_seen  <= 1'b0;
      end else begin
         rsp_error <= go_resp && c_err;
         if (go_resp) begin
            if (c_write || c_err)
               rsp_rdata <= '0;
            else
               rsp_rdata <= mem[c_idx];
         end
         if (go_resp && c_err)
            err_seen <= 1'b1;
      end
   end

endmodule
